zapper_multi_ctrl: RTL and testbench

Parametrised successor to the duck_hunt light-gun front end. Supports N_GUNS light guns, each with synchronised, debounced trigger and light-sensor inputs and configurable active polarity. A shared shot sequencer runs the NES-style sequence: arm, one black frame, then WHITE_FRAMES target frames. The VGA renderer draws the frames requested by flash_req/flash_white. The block returns a per-gun hit result to game logic.

---
 rtl/zapper_multi_ctrl.sv | 152 +++++++++++++++
 tb/tb_zapper_multi_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/zapper_multi_ctrl.sv
// Multi-gun light-gun front end: per-gun input sync and trigger debounce, plus a
// shared arm/black/white shot sequencer that reports which guns fired and hit.
module zapper_multi_ctrl #(
    parameter int N_GUNS           = 2,
    parameter int DEB_CYCLES       = 16,
    parameter int WHITE_FRAMES     = 1,
    parameter int TRIG_ACTIVE_LOW  = 1,
    parameter int LIGHT_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [N_GUNS-1:0] trigger_in,
    input  logic [N_GUNS-1:0] light_in,
    output logic              flash_req,
    output logic              flash_white,
    output logic              busy,
    output logic [N_GUNS-1:0] shot,
    output logic [N_GUNS-1:0] hit,
    output logic              hit_valid
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int FW = $clog2(WHITE_FRAMES + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(WHITE_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BLACK,
        S_WHITE,
        S_REPORT
    } state_t;

    state_t state;

    logic [N_GUNS-1:0] trig_raw, light_raw;
    logic [N_GUNS-1:0] trig_s1, trig_s2, light_s1, light_s2;
    logic [N_GUNS-1:0] deb, press;
    logic [DW-1:0]     deb_cnt [N_GUNS];
    logic [N_GUNS-1:0] shot_mask, fail, hit_flags, hit_upd;
    logic [FW-1:0]     frame_cnt;

    // Normalise polarity before synchronising so reset "released" is simply 0.
    assign trig_raw  = (TRIG_ACTIVE_LOW != 0)  ? ~trigger_in : trigger_in;
    assign light_raw = (LIGHT_ACTIVE_LOW != 0) ? ~light_in   : light_in;

    assign hit_upd = hit_flags | (light_s2 & shot_mask & ~fail);

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1  <= '0;
            trig_s2  <= '0;
            light_s1 <= '0;
            light_s2 <= '0;
            deb      <= '0;
            press    <= '0;
            for (int i = 0; i < N_GUNS; i++) deb_cnt[i] <= '0;
        end else begin
            trig_s1  <= trig_raw;
            trig_s2  <= trig_s1;
            light_s1 <= light_raw;
            light_s2 <= light_s1;
            press    <= '0;
            for (int i = 0; i < N_GUNS; i++) begin
                if (trig_s2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= ~deb[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Outputs are registered alongside the state, so they always match it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            flash_req   <= 1'b0;
            flash_white <= 1'b0;
            busy        <= 1'b0;
            shot        <= '0;
            hit         <= '0;
            hit_valid   <= 1'b0;
            shot_mask   <= '0;
            fail        <= '0;
            hit_flags   <= '0;
            frame_cnt   <= '0;
        end else begin
            hit_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|press) begin
                        shot_mask <= press;
                        fail      <= '0;
                        hit_flags <= '0;
                        busy      <= 1'b1;
                        state     <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (frame_start) begin
                        flash_req   <= 1'b1;
                        flash_white <= 1'b0;
                        state       <= S_BLACK;
                    end
                end
                S_BLACK: begin
                    fail <= fail | (light_s2 & shot_mask);
                    if (frame_start) begin
                        frame_cnt   <= '0;
                        flash_white <= 1'b1;
                        state       <= S_WHITE;
                    end
                end
                S_WHITE: begin
                    hit_flags <= hit_upd;
                    if (frame_start) begin
                        if (frame_cnt == FRAME_LAST) begin
                            flash_req   <= 1'b0;
                            flash_white <= 1'b0;
                            hit_valid   <= 1'b1;
                            shot        <= shot_mask;
                            hit         <= hit_upd;
                            state       <= S_REPORT;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_REPORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy        <= 1'b0;
                    flash_req   <= 1'b0;
                    flash_white <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zapper_multi_ctrl.sv
// Directed bench: one instance with a single white frame, one with three white
// frames; shot scenarios come from a vector table, corner cases are hand-written.
module tb_zapper_multi_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs1, fs3;
    logic [1:0] trig1, light1, trig3, light3;
    logic       flash_req1, flash_white1, busy1, hit_valid1;
    logic [1:0] shot1, hit1;
    logic       flash_req3, flash_white3, busy3, hit_valid3;
    logic [1:0] shot3, hit3;

    int checks = 0;
    int errors = 0;
    int hv1 = 0;
    int hv3 = 0;

    always #5 clk = ~clk;

    zapper_multi_ctrl #(.N_GUNS(2), .DEB_CYCLES(4), .WHITE_FRAMES(1),
                        .TRIG_ACTIVE_LOW(1), .LIGHT_ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .rst(rst), .frame_start(fs1), .trigger_in(trig1), .light_in(light1),
        .flash_req(flash_req1), .flash_white(flash_white1), .busy(busy1),
        .shot(shot1), .hit(hit1), .hit_valid(hit_valid1)
    );

    zapper_multi_ctrl #(.N_GUNS(2), .DEB_CYCLES(4), .WHITE_FRAMES(3),
                        .TRIG_ACTIVE_LOW(1), .LIGHT_ACTIVE_LOW(1)) u_dut3 (
        .clk(clk), .rst(rst), .frame_start(fs3), .trigger_in(trig3), .light_in(light3),
        .flash_req(flash_req3), .flash_white(flash_white3), .busy(busy3),
        .shot(shot3), .hit(hit3), .hit_valid(hit_valid3)
    );

    always @(posedge clk) begin
        if (hit_valid1 === 1'b1) hv1++;
        if (hit_valid3 === 1'b1) hv3++;
    end

    typedef struct {
        logic [1:0] guns;
        logic [1:0] light_black;
        logic [1:0] light_white;
        logic [1:0] exp_shot;
        logic [1:0] exp_hit;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_fs1();
        fs1 = 1'b1;
        tick();
        fs1 = 1'b0;
    endtask

    task automatic pulse_fs3();
        fs3 = 1'b1;
        tick();
        fs3 = 1'b0;
    endtask

    task automatic run_shot(input vec_t v, input bit release_after);
        int hv_start;
        hv_start = hv1;
        trig1 = ~v.guns;
        repeat (6) tick();
        chk("busy_before_latency", busy1, 0);
        tick();
        chk("busy_rise", busy1, 1);
        chk("arm_flash_req", flash_req1, 0);
        repeat (2) tick();
        pulse_fs1();
        chk("black_flash_req", flash_req1, 1);
        chk("black_flash_white", flash_white1, 0);
        light1 = ~v.light_black;
        repeat (8) tick();
        pulse_fs1();
        chk("white_flash_req", flash_req1, 1);
        chk("white_flash_white", flash_white1, 1);
        light1 = ~v.light_white;
        repeat (8) tick();
        pulse_fs1();
        chk("report_hit_valid", hit_valid1, 1);
        chk("report_shot", shot1, v.exp_shot);
        chk("report_hit", hit1, v.exp_hit);
        chk("report_flash_req", flash_req1, 0);
        light1 = 2'b11;
        tick();
        chk("post_hit_valid", hit_valid1, 0);
        chk("post_busy", busy1, 0);
        chk("post_shot_hold", shot1, v.exp_shot);
        chk("hit_valid_once", 8'(hv1 - hv_start), 1);
        if (release_after) begin
            trig1 = 2'b11;
            repeat (10) tick();
        end
    endtask

    task automatic run3(input logic [1:0] guns, input logic [5:0] lw, input logic [1:0] exp_hit);
        int hv_start;
        hv_start = hv3;
        trig3 = ~guns;
        repeat (7) tick();
        chk("w3_busy_rise", busy3, 1);
        pulse_fs3();
        repeat (8) tick();
        pulse_fs3();
        for (int f = 0; f < 3; f++) begin
            light3 = ~lw[f*2 +: 2];
            repeat (8) tick();
            if (f < 2) begin
                pulse_fs3();
                chk("w3_no_early_report", hit_valid3, 0);
                chk("w3_flash_white", flash_white3, 1);
            end
        end
        pulse_fs3();
        chk("w3_hit_valid", hit_valid3, 1);
        chk("w3_shot", shot3, guns);
        chk("w3_hit", hit3, exp_hit);
        light3 = 2'b11;
        tick();
        chk("w3_post_busy", busy3, 0);
        chk("w3_hit_valid_once", 8'(hv3 - hv_start), 1);
        trig3 = 2'b11;
        repeat (10) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int hv_start;

        //                guns   black  white  shot   hit
        vecs[0] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
        vecs[1] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        vecs[2] = '{2'b11, 2'b00, 2'b10, 2'b11, 2'b10};
        vecs[3] = '{2'b10, 2'b00, 2'b11, 2'b10, 2'b10};
        vecs[4] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10};
        vecs[5] = '{2'b11, 2'b00, 2'b00, 2'b11, 2'b00};

        rst = 1'b1;
        fs1 = 1'b0; fs3 = 1'b0;
        trig1 = 2'b11; light1 = 2'b11;
        trig3 = 2'b11; light3 = 2'b11;
        repeat (3) tick();
        chk("rst_flash_req", flash_req1, 0);
        chk("rst_flash_white", flash_white1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_shot", shot1, 0);
        chk("rst_hit", hit1, 0);
        chk("rst_hit_valid", hit_valid1, 0);
        chk("rst_busy3", busy3, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_no_press", busy1, 0);

        for (int i = 0; i < 6; i++) run_shot(vecs[i], 1'b1);

        // Bounce shorter than the debounce window never presses.
        bad = 1'b0;
        for (int r = 0; r < 5; r++) begin
            trig1 = 2'b10;
            repeat (3) begin tick(); if (busy1 !== 1'b0) bad = 1'b1; end
            trig1 = 2'b11;
            repeat (3) begin tick(); if (busy1 !== 1'b0) bad = 1'b1; end
        end
        repeat (10) begin tick(); if (busy1 !== 1'b0) bad = 1'b1; end
        chk("bounce_no_press", bad, 0);

        // Held triggers after a shot must not fire again.
        run_shot(vecs[2], 1'b0);
        hv_start = hv1;
        bad = 1'b0;
        for (int r = 0; r < 10; r++) begin
            pulse_fs1();
            repeat (4) begin tick(); if (busy1 !== 1'b0) bad = 1'b1; end
        end
        chk("held_no_second_shot", bad, 0);
        chk("held_no_hit_valid", 8'(hv1 - hv_start), 0);
        trig1 = 2'b11;
        repeat (10) tick();
        run_shot(vecs[0], 1'b1);

        run3(2'b01, 6'b01_00_00, 2'b01);

        // Reset in the middle of a white frame aborts without a report.
        hv_start = hv3;
        trig3 = 2'b10;
        repeat (7) tick();
        chk("mid_busy", busy3, 1);
        pulse_fs3();
        repeat (4) tick();
        pulse_fs3();
        repeat (3) tick();
        chk("mid_in_white", flash_white3, 1);
        rst = 1'b1;
        trig3 = 2'b11;
        tick();
        chk("mid_rst_flash_req", flash_req3, 0);
        chk("mid_rst_busy", busy3, 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_rst_no_hit_valid", 8'(hv3 - hv_start), 0);
        run3(2'b01, 6'b01_01_01, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
